// File: rtl/fir_decim_mc.sv
// Multi-channel FIR decimator. Time-interleaved channels are collected
// into per-channel delay lines; after DECIMATION samples per channel one
// output per channel is computed on a single shared multiply-accumulate
// unit and pushed to the output FIFO in channel order.
module fir_decim_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int CHANNELS   = 2,
  parameter int FRAC_BITS  = 10,
  // Default response: moving-average low-pass with unity DC gain.
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF =
    {TAPS{DATA_WIDTH'((1 << FRAC_BITS) / TAPS)}},
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_empty,
  output logic                  x_rd_en,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [CH_W-1:0]       y_chan,
  input  logic                  y_out_full,
  output logic                  y_wr_en
);

  localparam int TAP_W  = $clog2(TAPS);
  localparam int SMP_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(DECIMATION - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  logic [1:0]                   state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [SMP_W-1:0]             smp_q, smp_d;
  logic [TAP_W-1:0]             tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] dly_q [CHANNELS][TAPS];

  logic                         pop;
  logic [TAP_W-1:0]             cidx;
  logic signed [DATA_WIDTH-1:0] coef_s;
  logic signed [DATA_WIDTH-1:0] samp_s;
  logic signed [PROD_W-1:0]     prod_s;

  // Dequantize a full-width product: arithmetic shift (floor), then wrap
  // to the accumulator width.
  function automatic logic signed [DATA_WIDTH-1:0] deq(
    input logic signed [PROD_W-1:0] p
  );
    return DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  // Pop only in the load phase; a FIFO must never be popped under reset.
  assign pop = (state_q == S_LOAD) && !x_empty && !reset;

  // Shared MAC operands: reversed coefficient against the selected tap.
  always_comb begin
    cidx   = TAP_LAST - tap_q;
    coef_s = $signed(COEFF[cidx]);
    samp_s = dly_q[ch_q][tap_q];
    prod_s = PROD_W'(coef_s) * PROD_W'(samp_s);
  end

  // Next-state logic for the load / MAC / write sequence.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    smp_d   = smp_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    case (state_q)
      S_LOAD: begin
        if (!x_empty) begin
          if (ch_q == CH_LAST) begin
            ch_d = '0;
            if (smp_q == SMP_LAST) begin
              smp_d   = '0;
              tap_d   = '0;
              acc_d   = '0;
              state_d = S_MAC;
            end else begin
              smp_d = smp_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + deq(prod_s);
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = S_WRITE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WRITE: begin
        // A full output FIFO freezes everything, including the result.
        if (!y_out_full) begin
          tap_d = '0;
          acc_d = '0;
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            smp_d   = '0;
            state_d = S_LOAD;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_MAC;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        ch_d    = '0;
        smp_d   = '0;
        tap_d   = '0;
        acc_d   = '0;
      end
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      ch_q    <= '0;
      smp_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      smp_q   <= smp_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
    end
  end

  // Per-channel delay lines; history survives across blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          dly_q[c][k] <= '0;
        end
      end
    end else if (pop) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        dly_q[ch_q][k] <= dly_q[ch_q][k-1];
      end
      dly_q[ch_q][0] <= $signed(x_in);
    end
  end

  assign x_rd_en = pop;
  assign y_wr_en = (state_q == S_WRITE) && !y_out_full && !reset;
  assign y_out   = (state_q == S_WRITE) ? acc_q : '0;
  assign y_chan  = (state_q == S_WRITE) ? ch_q  : '0;

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed bench for fir_decim_mc with a 4-tap, decimate-by-2, 2-channel
// configuration and hand-computed expected outputs.
module tb_fir_decim_mc;

  localparam int DW   = 32;
  localparam int TAPS = 4;
  localparam int DEC  = 2;
  localparam int CH   = 2;
  localparam int FB   = 10;
  localparam logic [0:TAPS-1][DW-1:0] CF =
    {32'd1024, 32'd2048, 32'd3072, 32'd4096};

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] x_in;
  logic          x_empty;
  logic          x_rd_en;
  logic [DW-1:0] y_out;
  logic [0:0]    y_chan;
  logic          y_out_full;
  logic          y_wr_en;

  int     n_vec = 0;
  int     n_bad = 0;
  longint wr_y   [2];
  longint wr_ch  [2];
  int     wr_cyc [2];
  int     n_wr;
  int     last_pop;

  always #5 clock = ~clock;

  fir_decim_mc #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS),
    .DECIMATION (DEC),
    .CHANNELS   (CH),
    .FRAC_BITS  (FB),
    .COEFF      (CF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .x_empty    (x_empty),
    .x_rd_en    (x_rd_en),
    .y_out      (y_out),
    .y_chan     (y_chan),
    .y_out_full (y_out_full),
    .y_wr_en    (y_wr_en)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset      = 1'b1;
    x_empty    = 1'b0;
    y_out_full = 1'b0;
    #2;
    chk("rst_rd_en", x_rd_en, 0);
    chk("rst_wr_en", y_wr_en, 0);
    chk("rst_y",     $signed(y_out), 0);
    chk("rst_chan",  y_chan, 0);
    @(posedge clock); #1;
    reset   = 1'b0;
    x_empty = 1'b1;
  endtask

  // Feed one block of four words (ch0,ch1,ch0,ch1) and record writes.
  task automatic run_block(input longint w0, input longint w1,
                           input longint w2, input longint w3,
                           input bit gap, input bit hold, input bit rst_mid);
    longint words [4];
    int     idx;
    int     cyc;
    bit     done;
    longint held_y;
    words  = '{w0, w1, w2, w3};
    idx    = 0;
    cyc    = 0;
    done   = 1'b0;
    held_y = 0;
    n_wr   = 0;
    last_pop = -100;
    for (int i = 0; i < 2; i++) begin
      wr_y[i] = -999; wr_ch[i] = -999; wr_cyc[i] = -999;
    end
    @(posedge clock); #1;
    while (!done) begin
      x_in = '0;
      if (idx < 4) x_in = DW'(words[idx]);
      x_empty    = (idx >= 4) || (gap && (cyc % 2 == 1));
      y_out_full = hold && (idx == 4) && (cyc >= last_pop + 5) && (cyc <= last_pop + 14);
      if (rst_mid && idx == 4 && cyc == last_pop + 7) begin
        reset   = 1'b1;
        x_empty = 1'b0;
      end
      if (rst_mid && idx == 4 && cyc == last_pop + 9) reset = 1'b0;
      #2;
      if (x_empty) chk("rd_when_empty", x_rd_en, 0);
      if (rst_mid && idx == 4 && cyc == last_pop + 7) begin
        chk("midrst_rd_en", x_rd_en, 0);
        chk("midrst_wr_en", y_wr_en, 0);
        chk("midrst_y",     $signed(y_out), 0);
        chk("midrst_chan",  y_chan, 0);
      end
      if (hold && idx == 4 && cyc >= last_pop + 5 && cyc <= last_pop + 14) begin
        if (cyc == last_pop + 5) held_y = $signed(y_out);
        chk("bp_wr_en", y_wr_en, 0);
        chk("bp_rd_en", x_rd_en, 0);
        if (cyc > last_pop + 5) begin
          chk("bp_y_stable", $signed(y_out), held_y);
          chk("bp_chan_stable", y_chan, 0);
        end
      end
      if (x_rd_en && !x_empty) begin
        idx++;
        last_pop = cyc;
      end
      if (y_wr_en) begin
        if (n_wr < 2) begin
          wr_y[n_wr]   = $signed(y_out);
          wr_ch[n_wr]  = y_chan;
          wr_cyc[n_wr] = cyc;
        end
        n_wr++;
      end
      if (!rst_mid && n_wr >= 2) done = 1'b1;
      if (rst_mid && idx == 4 && cyc >= last_pop + 25) done = 1'b1;
      cyc++;
      if (!done && cyc > 300) begin
        chk("timeout_writes", n_wr, rst_mid ? 1 : 2);
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    x_empty    = 1'b1;
    y_out_full = 1'b0;
    #2;
    if (!rst_mid) chk("wr_one_cycle", y_wr_en, 0);
    if (hold) chk("bp_same_data", wr_y[0], held_y);
  endtask

  task automatic chk_pair(input string tag, input longint y0, input longint y1,
                          input int d0, input int d1);
    chk({tag, "_nwr"},  n_wr, 2);
    chk({tag, "_y0"},   wr_y[0], y0);
    chk({tag, "_ch0"},  wr_ch[0], 0);
    chk({tag, "_y1"},   wr_y[1], y1);
    chk({tag, "_ch1"},  wr_ch[1], 1);
    chk({tag, "_lat0"}, wr_cyc[0] - last_pop, d0);
    chk({tag, "_lat1"}, wr_cyc[1] - last_pop, d1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    x_in       = '0;
    x_empty    = 1'b1;
    y_out_full = 1'b0;

    // Impulse on ch0 lands on tap 1: 3072*100 >> 10 = 300.
    do_reset();
    run_block(100, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_pair("imp", 300, 0, 5, 10);

    // ch0: -4 + 3 = -1, ch1: floor(3072*-8 / 1024) = -24.
    do_reset();
    run_block(1, -8, -1, 0, 1'b0, 1'b0, 1'b0);
    chk_pair("sgn", -1, -24, 5, 10);

    // Output FIFO full for 10 cycles on the first write.
    do_reset();
    run_block(100, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk_pair("bp", 300, 0, 15, 20);

    // Input gaps every other cycle: same results as back-to-back.
    do_reset();
    run_block(1, -8, -1, 0, 1'b1, 1'b0, 1'b0);
    chk_pair("gap", -1, -24, 5, 10);

    // Reset during ch1 MAC: only the ch0 write escapes.
    do_reset();
    run_block(100, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("midrst_nwr", n_wr, 1);
    chk("midrst_y0",  wr_y[0], 300);
    run_block(100, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_pair("rerun", 300, 0, 5, 10);

    // History carries over: ch0 line is now -1,1,0,100 -> -4+3+0+100 = 99.
    run_block(1, -8, -1, 0, 1'b0, 1'b0, 1'b0);
    chk_pair("hist", 99, -24, 5, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
